// File: rtl/fork_join_timer.sv
// fork_join_timer: a bank of NUM_CH countdown channels launched together by one
// start, with a join detector giving SV fork join / join_any / join_none semantics.
// Each channel with a nonzero count completes after exactly that many posedges.
// kill aborts every running channel silently. A start while busy is ignored and
// flagged with start_err.
module fork_join_timer #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [NUM_CH*CNT_W-1:0]   counts,
    input  logic                      kill,
    output logic                      busy,
    output logic [NUM_CH-1:0]         ch_active,
    output logic [NUM_CH-1:0]         ch_done,
    output logic                      join_done,
    output logic                      start_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        JM_ALL  = 2'd0,
        JM_ANY  = 2'd1,
        JM_NONE = 2'd2
    } join_mode_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [NUM_CH-1:0] ch_active_r;
    logic [NUM_CH-1:0] ch_done_r;
    logic              busy_r;
    logic              join_done_r;
    logic              start_err_r;
    state_t            state_r;
    join_mode_t        mode_r;

    logic [NUM_CH-1:0] fin_s;
    logic [NUM_CH-1:0] launch_s;
    logic [NUM_CH-1:0] act_next_s;
    logic              accept_s;
    logic              reject_s;
    join_mode_t        mode_dec_s;

    // Per-channel finish/launch flags, start arbitration and join-mode decode.
    always_comb begin
        fin_s    = {NUM_CH{1'b0}};
        launch_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            fin_s[i]    = ch_active_r[i] && (cnt_r[i] == CNT_ONE);
            launch_s[i] = (counts[i*CNT_W +: CNT_W] != CNT_ZERO);
        end
        act_next_s = ch_active_r & ~fin_s;
        // busy is registered, so a start on the edge the last channel ends is rejected.
        accept_s   = start && !busy_r && !kill;
        reject_s   = start &&  busy_r && !kill;
        case (mode)
            2'b01:   mode_dec_s = JM_ANY;
            2'b10:   mode_dec_s = JM_NONE;
            default: mode_dec_s = JM_ALL;
        endcase
    end

    // Channel counters: load on accepted start, count down to zero, clear on kill.
    always_ff @(posedge clock) begin
        if (reset || kill) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            ch_active_r <= {NUM_CH{1'b0}};
        end else if (accept_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= counts[i*CNT_W +: CNT_W];
            end
            ch_active_r <= launch_s;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_active_r[i] && (cnt_r[i] != CNT_ZERO)) begin
                    cnt_r[i] <= cnt_r[i] - CNT_ONE;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
            ch_active_r <= act_next_s;
        end
    end

    // Join FSM and the registered status/pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mode_r      <= JM_ALL;
            busy_r      <= 1'b0;
            ch_done_r   <= {NUM_CH{1'b0}};
            join_done_r <= 1'b0;
            start_err_r <= 1'b0;
        end else if (kill) begin
            // Abort: no completion pulses, start on this edge is dropped.
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            ch_done_r   <= {NUM_CH{1'b0}};
            join_done_r <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            ch_done_r   <= fin_s;
            join_done_r <= 1'b0;
            start_err_r <= reject_s;
            busy_r      <= |act_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mode_r <= mode_dec_s;
                        busy_r <= |launch_s;
                        if (launch_s == {NUM_CH{1'b0}}) begin
                            // Nothing to run: the fork is trivially joined.
                            join_done_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else if (mode_dec_s == JM_NONE) begin
                            join_done_r <= 1'b1;
                            state_r     <= ST_DRAIN;
                        end else begin
                            state_r     <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (mode_r == JM_ANY) begin
                        if (fin_s != {NUM_CH{1'b0}}) begin
                            join_done_r <= 1'b1;
                            state_r     <= (act_next_s == {NUM_CH{1'b0}}) ? ST_IDLE : ST_DRAIN;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        if (act_next_s == {NUM_CH{1'b0}}) begin
                            join_done_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (act_next_s == {NUM_CH{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign ch_active = ch_active_r;
    assign ch_done   = ch_done_r;
    assign join_done = join_done_r;
    assign start_err = start_err_r;

endmodule

// File: tb/tb_fork_join_timer.sv
// Bench for fork_join_timer: directed scenarios plus random stimulus, checked
// every cycle against a timeline model (absolute finish edge per channel and
// the edge at which the join fires).
module tb_fork_join_timer;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    start;
    logic [1:0]              mode;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic                    kill;
    logic                    busy;
    logic [NUM_CH-1:0]       ch_active;
    logic [NUM_CH-1:0]       ch_done;
    logic                    join_done;
    logic                    start_err;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int ch_end [NUM_CH];
    int join_at = -1;

    fork_join_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .counts    (counts),
        .kill      (kill),
        .busy      (busy),
        .ch_active (ch_active),
        .ch_done   (ch_done),
        .join_done (join_done),
        .start_err (start_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge, compare outputs.
    task automatic tick(input logic st, input logic kl, input logic rs,
                        input logic [1:0] md, input logic [NUM_CH*CNT_W-1:0] cn);
        logic              busy_prev;
        logic [NUM_CH-1:0] e_done;
        logic [NUM_CH-1:0] e_act;
        logic              e_join;
        logic              e_err;
        int                n;
        int                mx;
        int                mn;
        start  = st;
        kill   = kl;
        reset  = rs;
        mode   = md;
        counts = cn;
        @(posedge clock);
        edge_n++;
        busy_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_end[i] >= edge_n) busy_prev = 1'b1;
        end
        e_done = '0;
        e_join = 1'b0;
        e_err  = 1'b0;
        if (rs || kl) begin
            for (int i = 0; i < NUM_CH; i++) ch_end[i] = -1;
            join_at = -1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) e_done[i] = (ch_end[i] == edge_n);
            e_join = (join_at == edge_n);
            e_err  = st && busy_prev;
            if (st && !busy_prev) begin
                mx = 0;
                mn = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    n = int'(cn[i*CNT_W +: CNT_W]);
                    ch_end[i] = (n > 0) ? edge_n + n : -1;
                    if (n > mx) mx = n;
                    if (n > 0 && (mn == 0 || n < mn)) mn = n;
                end
                if (mx == 0 || md == 2'b10) join_at = edge_n;
                else if (md == 2'b01)       join_at = edge_n + mn;
                else                        join_at = edge_n + mx;
                if (join_at == edge_n) e_join = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) e_act[i] = (ch_end[i] > edge_n);
        #1;
        check_eq("ch_active", 32'(ch_active), 32'(e_act));
        check_eq("busy",      32'(busy),      32'(|e_act));
        check_eq("ch_done",   32'(ch_done),   32'(e_done));
        check_eq("join_done", 32'(join_done), 32'(e_join));
        check_eq("start_err", 32'(start_err), 32'(e_err));
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) tick(1'b0, 1'b0, 1'b0, 2'b00, '0);
    endtask

    logic [NUM_CH*CNT_W-1:0] base_cnt;
    logic [NUM_CH*CNT_W-1:0] rnd_cnt;
    int                      jpulses;

    initial begin
        for (int i = 0; i < NUM_CH; i++) ch_end[i] = -1;
        base_cnt = {8'd30, 8'd5, 8'd10};

        // Reset state.
        tick(1'b0, 1'b0, 1'b1, 2'b00, '0);
        tick(1'b0, 1'b0, 1'b1, 2'b00, '0);
        idle(2);

        // JOIN_ALL, JOIN_ANY, JOIN_NONE and mode 11 with the reference counts.
        for (int m = 0; m < 4; m++) begin
            tick(1'b1, 1'b0, 1'b0, 2'(m), base_cnt);
            idle(33);
        end

        // Second start at E12 of a JOIN_ALL run is rejected.
        tick(1'b1, 1'b0, 1'b0, 2'b00, base_cnt);
        idle(11);
        tick(1'b1, 1'b0, 1'b0, 2'b00, {8'd2, 8'd2, 8'd2});
        idle(20);
        // Start on the very edge the last channel completes is rejected too.
        tick(1'b1, 1'b0, 1'b0, 2'b00, {8'd0, 8'd0, 8'd3});
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 2'b00, {8'd1, 8'd1, 8'd1});
        idle(3);

        // kill at E7, fresh start at E9; then kill beats start; kill while idle.
        tick(1'b1, 1'b0, 1'b0, 2'b00, base_cnt);
        idle(6);
        tick(1'b0, 1'b1, 1'b0, 2'b00, '0);
        idle(1);
        tick(1'b1, 1'b0, 1'b0, 2'b01, {8'd4, 8'd6, 8'd1});
        idle(2);
        tick(1'b1, 1'b1, 1'b0, 2'b00, base_cnt);
        tick(1'b0, 1'b1, 1'b0, 2'b00, '0);
        tick(1'b1, 1'b1, 1'b0, 2'b00, base_cnt);
        idle(3);

        // All-zero counts in every mode.
        for (int m = 0; m < 4; m++) begin
            tick(1'b1, 1'b0, 1'b0, 2'(m), '0);
            idle(2);
        end

        // JOIN_ANY with coinciding first completions yields a single pulse.
        jpulses = 0;
        tick(1'b1, 1'b0, 1'b0, 2'b01, {8'd9, 8'd3, 8'd3});
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'b00, '0);
            if (join_done) jpulses++;
        end
        check_eq("any_single_join", 32'(jpulses), 32'd1);

        // Maximum count on one channel.
        tick(1'b1, 1'b0, 1'b0, 2'b00, {8'd0, 8'd255, 8'd0});
        idle(257);

        // Reset at E3 of a run aborts silently.
        tick(1'b1, 1'b0, 1'b0, 2'b00, base_cnt);
        idle(2);
        tick(1'b0, 1'b0, 1'b1, 2'b00, '0);
        idle(35);

        // Random stimulus.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rnd_cnt[i*CNT_W +: CNT_W] = ($urandom_range(0, 3) == 0) ? 8'd0
                                            : 8'($urandom_range(1, 20));
            end
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 149) == 0, 2'($urandom_range(0, 3)), rnd_cnt);
        end
        idle(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
